// File: rtl/ram_loader.sv
// ram_loader: fills the shared RAM from a valid/ready byte stream starting at BASE,
// reads the region back, and compares an 8-bit additive checksum of both passes.
// While own is high the top-level mux hands this block's adrs/rw/dout to the RAM.
module ram_loader #(
  parameter logic [7:0] BASE = 8'h00
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [7:0]  adrs,
  output logic        rw,
  output logic [7:0]  dout,
  input  logic [15:0] din,
  output logic        own,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRaddr,
    StRlast,
    StCheck
  } state_t;

  state_t     state;
  logic [7:0] cnt;   // current offset from BASE
  logic [7:0] n;     // latched byte count
  logic [7:0] wsum;  // running sum of written bytes
  logic [7:0] rsum;  // running sum of read-back bytes

  // Only the low byte of the RAM read port carries loaded data.
  logic unused_din;
  assign unused_din = ^din[15:8];

  // Sequencer: phase transitions, offset counter, checksums and registered status flags.
  // own is registered so it drops in the same cycle the done pulse appears.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= StIdle;
      cnt   <= 8'h00;
      n     <= 8'h00;
      wsum  <= 8'h00;
      rsum  <= 8'h00;
      own   <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            err <= 1'b0;
            if (len != 8'h00) begin
              n     <= len;
              cnt   <= 8'h00;
              wsum  <= 8'h00;
              rsum  <= 8'h00;
              own   <= 1'b1;
              state <= StWrite;
            end else begin
              // Empty load: report completion without touching the bus.
              done <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (s_valid) begin
            wsum <= wsum + s_data;
            if (cnt == n - 8'd1) begin
              cnt   <= 8'h00;
              state <= StRaddr;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        StRaddr: begin
          // din lags the address by one cycle, so the first RADDR cycle has nothing to add.
          if (cnt != 8'h00) begin
            rsum <= rsum + din[7:0];
          end
          if (cnt == n - 8'd1) begin
            state <= StRlast;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StRlast: begin
          rsum  <= rsum + din[7:0];
          state <= StCheck;
        end
        StCheck: begin
          err   <= (wsum != rsum);
          done  <= 1'b1;
          own   <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Bus outputs: write strobe and data follow s_valid/s_data directly during WRITE.
  // clr masks acceptance so a byte presented in a reset cycle is never written.
  always_comb begin
    s_ready = 1'b0;
    rw      = 1'b1;
    adrs    = BASE;
    dout    = 8'h00;
    unique case (state)
      StWrite: begin
        s_ready = !clr;
        rw      = !(s_valid && !clr);
        adrs    = BASE + cnt;
        dout    = s_data;
      end
      StRaddr, StRlast, StCheck: begin
        adrs = BASE + cnt;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (BASE 00 and FE) share one stimulus stream.
// Stimulus pushes expected bus writes, read addresses and done/err results into queues;
// a negedge monitor pops and compares whenever a DUT shows a write, a read or done.
module tb_ram_loader;

  localparam int ND = 2;
  localparam logic [7:0] BASES [ND] = '{8'h00, 8'hFE};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, start, s_valid;
  logic [7:0] len, s_data;

  logic        s_ready [ND];
  logic [7:0]  adrs    [ND];
  logic        rw      [ND];
  logic [7:0]  dout    [ND];
  logic [15:0] din     [ND];
  logic        own     [ND];
  logic        done    [ND];
  logic        err     [ND];

  ram_loader #(.BASE(8'h00)) u_dut0 (
    .clk(clk), .clr(clr), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready[0]), .adrs(adrs[0]), .rw(rw[0]), .dout(dout[0]), .din(din[0]),
    .own(own[0]), .done(done[0]), .err(err[0])
  );

  ram_loader #(.BASE(8'hFE)) u_dut1 (
    .clk(clk), .clr(clr), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready[1]), .adrs(adrs[1]), .rw(rw[1]), .dout(dout[1]), .din(din[1]),
    .own(own[1]), .done(done[1]), .err(err[1])
  );

  // RAM models: write when rw=0, one-cycle read latency, optional bit-0 flip at BASE+2.
  logic [7:0] ram [ND][256];
  bit         corrupt = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rw[d]) ram[d][adrs[d]] <= dout[d];
      din[d] <= {8'($urandom),
                 ram[d][adrs[d]] ^ ((corrupt && adrs[d] == BASES[d] + 8'd2) ? 8'h01 : 8'h00)};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [15:0] exp_wr       [ND][$];
  logic [7:0]  exp_rd       [ND][$];
  int          exp_done_cyc [ND][$];
  logic        exp_done_err [ND][$];
  logic        err_model    [ND];
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  bytes [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_evt(input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        logic [15:0] w;
        if (!rw[d]) begin
          if (exp_wr[d].size() == 0) begin
            fail_evt($sformatf("unexpected write dut%0d: got adrs %0h data %0h, expected none",
                               d, adrs[d], dout[d]));
          end else begin
            w = exp_wr[d].pop_front();
            check($sformatf("write addr dut%0d", d), 32'(adrs[d]), 32'(w[15:8]));
            check($sformatf("write data dut%0d", d), 32'(dout[d]), 32'(w[7:0]));
            check($sformatf("own during write dut%0d", d), 32'(own[d]), 32'd1);
          end
        end else if (own[d] && !s_ready[d] && exp_rd[d].size() != 0) begin
          check($sformatf("read addr dut%0d", d), 32'(adrs[d]), 32'(exp_rd[d].pop_front()));
        end
        if (done[d]) begin
          if (exp_done_cyc[d].size() == 0) begin
            fail_evt($sformatf("unexpected done dut%0d: got done=1, expected 0", d));
          end else begin
            check($sformatf("done cycle dut%0d", d), 32'(cyc), 32'(exp_done_cyc[d].pop_front()));
            err_model[d] = exp_done_err[d].pop_front();
            check($sformatf("own low with done dut%0d", d), 32'(own[d]), 32'd0);
            check($sformatf("reads finished at done dut%0d", d), 32'(exp_rd[d].size()), 32'd0);
          end
        end
        check($sformatf("err dut%0d", d), 32'(err[d]), 32'(err_model[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s own dut%0d", tag, d), 32'(own[d]), 32'd0);
      check($sformatf("%s rw dut%0d", tag, d), 32'(rw[d]), 32'd1);
      check($sformatf("%s adrs dut%0d", tag, d), 32'(adrs[d]), 32'(BASES[d]));
      check($sformatf("%s dout dut%0d", tag, d), 32'(dout[d]), 32'd0);
      check($sformatf("%s s_ready dut%0d", tag, d), 32'(s_ready[d]), 32'd0);
      check($sformatf("%s done dut%0d", tag, d), 32'(done[d]), 32'd0);
      check($sformatf("%s err dut%0d", tag, d), 32'(err[d]), 32'd0);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
  endtask

  task automatic flush();
    for (int d = 0; d < ND; d++) begin
      exp_wr[d].delete();
      exp_rd[d].delete();
      exp_done_cyc[d].delete();
      exp_done_err[d].delete();
    end
  endtask

  // stall: 0 = continuous, 1 = alternate valid/idle, 2 = random gaps.
  // abort_at >= 0 asserts clr that many cycles into the read-back phase.
  task automatic do_load(input int n, input int stall, input bit corrupt_en,
                         input bit poke_start, input int abort_at);
    int  k0;
    int  w;
    int  acc;
    int  t;
    bit  v;
    corrupt = corrupt_en;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < n; i++) begin
        exp_wr[d].push_back({BASES[d] + 8'(i), bytes[i]});
        exp_rd[d].push_back(BASES[d] + 8'(i));
      end
    end
    start = 1'b1;
    len   = 8'(n);
    step();
    k0    = cyc;
    start = 1'b0;
    len   = 8'($urandom);
    for (int d = 0; d < ND; d++) err_model[d] = 1'b0;
    acc = 0;
    w   = 0;
    while (acc < n) begin
      if (stall == 0)      v = 1'b1;
      else if (stall == 1) v = (w % 2 == 0);
      else                 v = ($urandom_range(0, 2) != 0);
      s_valid = v;
      s_data  = v ? bytes[acc] : 8'($urandom);
      if (poke_start && w == 1) begin
        start = 1'b1;
        len   = 8'($urandom_range(1, 255));
      end else begin
        start = 1'b0;
      end
      step();
      w++;
      if (v) acc++;
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
    start   = 1'b0;
    if (abort_at < 0) begin
      for (int d = 0; d < ND; d++) begin
        exp_done_cyc[d].push_back((n == 0) ? k0 : k0 + w + n + 2);
        exp_done_err[d].push_back(corrupt_en && n >= 3);
      end
      t = 0;
      while ((exp_done_cyc[0].size() != 0 || exp_done_cyc[1].size() != 0) && t < 2000) begin
        step();
        t++;
      end
      if (t >= 2000) begin
        fail_evt("done timeout: got no done, expected one");
        flush();
      end
    end else begin
      for (int i = 0; i < abort_at; i++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int d = 0; d < ND; d++) begin
        exp_rd[d].delete();
        err_model[d] = 1'b0;
      end
      check_idle("after mid-read clr");
      for (int i = 0; i < 2 * n + 6; i++) step();
    end
    corrupt = 1'b0;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("ram content dut%0d", d), 32'(ram[d][BASES[d] + 8'(i)]), 32'(bytes[i]));
      end
      check($sformatf("writes drained dut%0d", d), 32'(exp_wr[d].size()), 32'd0);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      err_model[d] = 1'b0;
      for (int a = 0; a < 256; a++) ram[d][a] = 8'h00;
    end
    clr     = 1'b1;
    start   = 1'b0;
    len     = 8'h00;
    s_valid = 1'b0;
    s_data  = 8'h00;
    step();
    step();
    clr = 1'b0;
    check_idle("reset");
    mon_en = 1'b1;
    step();

    // Basic load
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    do_load(4, 0, 1'b0, 1'b0, -1);

    // Stalled stream
    bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'hFF;
    do_load(3, 1, 1'b0, 1'b0, -1);

    // Random bytes, four long (exercises the FE wrap on the second instance)
    fill_rand(4);
    do_load(4, 0, 1'b0, 1'b0, -1);

    // Corruption, then idle cycles with err held, then a clean load clears it
    fill_rand(5);
    do_load(5, 2, 1'b1, 1'b0, -1);
    for (int i = 0; i < 5; i++) step();

    // Zero-length load
    do_load(0, 0, 1'b0, 1'b0, -1);

    // start pulsed during WRITE
    fill_rand(6);
    do_load(6, 2, 1'b0, 1'b1, -1);

    // clr during RADDR
    fill_rand(5);
    do_load(5, 0, 1'b0, 1'b0, 2);

    // Maximum length
    fill_rand(255);
    do_load(255, 2, 1'b0, 1'b0, -1);

    // Random loads
    for (int r = 0; r < 8; r++) begin
      int rn;
      rn = $urandom_range(1, 40);
      fill_rand(rn);
      do_load(rn, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
